axi_lite_req_master: RTL and testbench

//   Single-outstanding AXI-Lite master sequencer.
//   - Converts a simple valid/ready request/response port into AXI-Lite read and write transactions.
//   - Sits directly upstream of bridge_1xM and drives its master side.
//   - Lets CPU-less control logic and benches reach all M slaves without hand-coding the AXI channels.
//   - Includes a sticky watchdog that flags transactions the fabric never completes.

---
 rtl/axi_lite_req_master.sv | 106 ++++++++++
 tb/tb_axi_lite_req_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_req_master.sv
// axi_lite_req_master: single-outstanding valid/ready to AXI-Lite master sequencer with sticky watchdog
module axi_lite_req_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  input  logic [1:0]              m_b_resp,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  output logic                    timeout
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0] cnt;
  logic accept, busy;
  assign m_aw_addr = addr;
  assign m_ar_addr = addr;
  always_comb begin
    req_ready = state == IDLE && !rst;
    accept = req_valid && req_ready;
    busy = state == WR || state == WRESP || state == RADDR || state == RDATA;
    m_b_ready = state == WRESP;
    m_r_ready = state == RDATA;
    rsp_valid = state == RESP;
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (req_write ? WR : RADDR) : IDLE;
      WR:      state_n = (!m_aw_valid || m_aw_ready) && (!m_w_valid || m_w_ready) ? WRESP : WR;
      WRESP:   state_n = m_b_valid ? RESP : WRESP;
      RADDR:   state_n = m_ar_ready ? RDATA : RADDR;
      RDATA:   state_n = m_r_valid ? RESP : RDATA;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      m_w_data <= '0;
      m_w_strb <= '0;
      m_aw_valid <= 1'b0;
      m_w_valid <= 1'b0;
      m_ar_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr <= req_addr;
        m_aw_valid <= req_write;
        m_w_valid <= req_write;
        m_ar_valid <= !req_write;
        cnt <= '0;
        if (req_write) begin
          m_w_data <= req_wdata;
          m_w_strb <= req_wstrb;
        end
      end
      if (m_aw_valid && m_aw_ready) m_aw_valid <= 1'b0;
      if (m_w_valid && m_w_ready) m_w_valid <= 1'b0;
      if (m_ar_valid && m_ar_ready) m_ar_valid <= 1'b0;
      if (m_b_ready && m_b_valid) begin
        rsp_resp <= m_b_resp;
        rsp_rdata <= '0;
      end
      if (m_r_ready && m_r_valid) begin
        rsp_resp <= m_r_resp;
        rsp_rdata <= m_r_data;
      end
      if (busy && cnt != TC) cnt <= cnt + 1'b1;
      if (busy && TIMEOUT_CYCLES != 0 && cnt + 1'b1 == TC) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_lite_req_master.sv
// tb_axi_lite_req_master: scoreboard bench with a memory slave model for axi_lite_req_master
module tb_axi_lite_req_master;
  logic clk, rst;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_wstrb;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, timeout;
  logic [3:0] m_w_strb;
  logic [1:0] m_b_resp, m_r_resp;

  axi_lite_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .timeout(timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] exp_d[$];
  logic [1:0] exp_r[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic ar_block = 0, b_block = 0;
  logic have_aw, have_w, ga, gw;
  logic [31:0] sa_addr, sw_data, a_eff, d_eff, merged;
  logic [3:0] sw_strb, s_eff;
  logic [31:0] mem [0:4095];

  function automatic logic [1:0] dec(input logic [31:0] a);
    return a < 32'h4000 ? 2'b00 : 2'b11;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    m_aw_ready = m_aw_valid && aw_wait >= aw_delay;
    m_w_ready = m_w_valid && w_wait >= w_delay;
    m_ar_ready = m_ar_valid && !ar_block;
    ga = have_aw || (m_aw_valid && m_aw_ready);
    gw = have_w || (m_w_valid && m_w_ready);
    a_eff = have_aw ? sa_addr : m_aw_addr;
    d_eff = have_w ? sw_data : m_w_data;
    s_eff = have_w ? sw_strb : m_w_strb;
    merged = mem[a_eff[13:2]];
    for (int i = 0; i < 4; i++) if (s_eff[i]) merged[8*i +: 8] = d_eff[8*i +: 8];
  end

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0;
      w_wait <= 0;
      have_aw <= 0;
      have_w <= 0;
      m_b_valid <= 0;
      m_b_resp <= 0;
      m_r_valid <= 0;
      m_r_resp <= 0;
      m_r_data <= 0;
    end else begin
      aw_wait <= (m_aw_valid && !m_aw_ready) ? aw_wait + 1 : 0;
      w_wait <= (m_w_valid && !m_w_ready) ? w_wait + 1 : 0;
      if (m_aw_valid && m_aw_ready) begin
        aw_hs <= aw_hs + 1;
        aw_cyc <= cyc;
        sa_addr <= m_aw_addr;
      end
      if (m_w_valid && m_w_ready) begin
        w_hs <= w_hs + 1;
        w_cyc <= cyc;
        sw_data <= m_w_data;
        sw_strb <= m_w_strb;
      end
      if (ga && gw && !m_b_valid && !b_block) begin
        m_b_valid <= 1;
        m_b_resp <= dec(a_eff);
        if (dec(a_eff) == 2'b00) mem[a_eff[13:2]] <= merged;
        have_aw <= 0;
        have_w <= 0;
      end else begin
        have_aw <= ga;
        have_w <= gw;
      end
      if (m_b_valid && m_b_ready) begin
        m_b_valid <= 0;
        b_hs <= b_hs + 1;
      end
      if (m_ar_valid && m_ar_ready) begin
        m_r_valid <= 1;
        m_r_resp <= dec(m_ar_addr);
        m_r_data <= dec(m_ar_addr) == 2'b00 ? mem[m_ar_addr[13:2]] : 32'h0;
      end
      if (m_r_valid && m_r_ready) m_r_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%h/%b expected=none", rsp_rdata, rsp_resp);
        end else begin
          chk("rsp_rdata", rsp_rdata, exp_d[0]);
          chk("rsp_resp", rsp_resp, exp_r[0]);
          if (rsp_ready) begin
            void'(exp_d.pop_front());
            void'(exp_r.pop_front());
          end
        end
      end
      chk("chan_excl", (m_aw_valid || m_w_valid || m_b_ready) && (m_ar_valid || m_r_ready), 0);
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] ed, input logic [1:0] er, input bit push);
    bit ok;
    ok = 0;
    if (push) begin
      exp_d.push_back(ed);
      exp_r.push_back(er);
    end
    req_valid = 1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_wstrb = s;
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 0;
    chk("accept", ok, 1);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && exp_d.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk(name, exp_d.size(), 0);
  endtask

  task automatic latency(input string name);
    @(posedge clk);
    #1;
    chk({name, "_early"}, rsp_valid, 0);
    @(posedge clk);
    #1;
    chk({name, "_on_time"}, rsp_valid, 1);
  endtask

  int b0, b1, b2;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1;
    req_valid = 0;
    req_write = 0;
    req_addr = 0;
    req_wdata = 0;
    req_wstrb = 0;
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outs", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready, rsp_valid, timeout}, 0);
    chk("rst_regs", {m_aw_addr, m_w_data, m_w_strb, rsp_rdata, rsp_resp}, 0);
    rst = 0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    issue(1, 32'h1000, 32'hDEAD_1000, 4'hF, 32'h0, 2'b00, 1);
    latency("wr_lat");
    drain("wr1_drain");
    chk("wr1_req_ready", req_ready, 1);
    issue(0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_1000, 2'b00, 1);
    latency("rd_lat");
    drain("rd1_drain");

    issue(0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 2'b11, 1);
    drain("decerr_drain");
    chk("decerr_req_ready", req_ready, 1);

    issue(1, 32'h2000, 32'hAABB_CCDD, 4'hF, 32'h0, 2'b00, 1);
    drain("strb_full");
    issue(1, 32'h2000, 32'h1122_3344, 4'b0101, 32'h0, 2'b00, 1);
    drain("strb_part");
    issue(0, 32'h2000, 32'h0, 4'h0, 32'hAA22_CC44, 2'b00, 1);
    drain("strb_read");

    issue(1, 32'h3000, 32'hDEAD_3000, 4'hF, 32'h0, 2'b00, 1);
    drain("stall_wr");
    rsp_ready = 0;
    issue(0, 32'h3000, 32'h0, 4'h0, 32'hDEAD_3000, 2'b00, 1);
    for (int n = 0; n < 50 && !rsp_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_rdata", rsp_rdata, 32'hDEAD_3000);
    end
    rsp_ready = 1;
    drain("stall_drain");

    aw_delay = 3;
    b0 = aw_hs;
    b1 = w_hs;
    b2 = b_hs;
    issue(1, 32'h0000, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 1);
    drain("skew_drain");
    chk("skew_aw_count", aw_hs - b0, 1);
    chk("skew_w_count", w_hs - b1, 1);
    chk("skew_b_count", b_hs - b2, 1);
    chk("skew_w_first", aw_cyc - w_cyc, 3);
    aw_delay = 0;
    issue(0, 32'h0000, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1);
    drain("skew_read");

    chk("wd_idle", timeout, 0);
    ar_block = 1;
    issue(0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_1000, 2'b00, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("wd_before", timeout, 0);
    @(posedge clk);
    #1;
    chk("wd_rise", timeout, 1);
    chk("wd_ar_held", m_ar_valid, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("wd_stay", timeout, 1);
    chk("wd_ar_still", m_ar_valid, 1);
    ar_block = 0;
    drain("wd_drain");
    chk("wd_sticky", timeout, 1);

    b_block = 1;
    issue(1, 32'h0004, 32'h0000_0055, 4'hF, 32'h0, 2'b00, 0);
    for (int n = 0; n < 50 && !m_b_ready; n++) begin
      @(posedge clk);
      #1;
    end
    chk("wresp_reached", m_b_ready, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_outs", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready, rsp_valid, timeout}, 0);
    rst = 0;
    b_block = 0;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    issue(0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_1000, 2'b00, 1);
    drain("recover_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
